mem_arbiter: RTL and testbench

//  Shares one single-port, fixed-latency memory between instruction fetch (IF)
//  and the execution unit's load/store path (EX). Per-requester req/gnt

---
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates one single-port fixed-latency memory between IF and EX, EX first, IF starvation-bounded.
// Latency: grant to if_valid/ex_done is MEM_LATENCY+2 cycles; one access in flight at a time.
// Backpressure: req/gnt handshake, no grant while busy; stall holds the pipeline until an EX access completes.
//
// Ports:
//   clk, rst             clock (rising edge) and asynchronous active-low reset
//   if_req/if_addr       fetch request (level) and address; if_gnt accepts it
//   if_valid/if_rdata    one-cycle completion pulse and fetched word (held)
//   ex_req/we/addr/wdata load/store request (level); ex_gnt accepts it
//   ex_done/ex_rdata     one-cycle completion pulse and load data (held)
//   stall                hold IF/EX pipeline registers
//   mem_*                memory strobe, write enable, address, write data, read data
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_valid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            ex_req,
  input  logic            ex_we,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  output logic            ex_gnt,
  output logic            ex_done,
  output logic [XLEN-1:0] ex_rdata,
  output logic            stall,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int CW = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_EX = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            if_valid_q, if_valid_d;
  logic            ex_done_q, ex_done_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic [XLEN-1:0] ex_rdata_q, ex_rdata_d;
  logic            sel_if, sel_ex, starve;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    scnt_d      = scnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    ex_done_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    ex_rdata_d  = ex_rdata_q;
    sel_if      = 1'b0;
    sel_ex      = 1'b0;
    starve      = 1'b0;

    case (state_q)
      IDLE: begin
        // IF has waited through STARVE_LIMIT consecutive EX grants: it wins this one.
        starve = if_req && (scnt_q == SW'(STARVE_LIMIT));
        if (ex_req && !starve) begin
          sel_ex = 1'b1;
        end else if (if_req) begin
          sel_if = 1'b1;
        end

        if (sel_ex) begin
          state_d     = BUSY_EX;
          cnt_d       = CW'(MEM_LATENCY);
          mem_en_d    = 1'b1;
          mem_we_d    = ex_we;
          mem_addr_d  = ex_addr;
          mem_wdata_d = ex_wdata;
          if (if_req) begin
            if (scnt_q != SW'(STARVE_LIMIT)) begin
              scnt_d = scnt_q + 1'b1;
            end
          end else begin
            scnt_d = '0;
          end
        end else if (sel_if) begin
          state_d    = BUSY_IF;
          cnt_d      = CW'(MEM_LATENCY);
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          scnt_d     = '0;
        end
      end

      BUSY_IF, BUSY_EX: begin
        // cnt hits zero exactly MEM_LATENCY cycles after the mem_en cycle,
        // which is when the memory presents read data.
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (state_q == BUSY_IF) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            if (!mem_we_q) begin
              ex_rdata_d = mem_rdata;
            end
            ex_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      scnt_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      ex_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      ex_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      scnt_q      <= scnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      ex_done_q   <= ex_done_d;
      if_rdata_q  <= if_rdata_d;
      ex_rdata_q  <= ex_rdata_d;
    end
  end

  // Grants are combinational from the requests, so they are gated by reset
  // to keep every output low while reset is asserted.
  assign if_gnt = rst && sel_if;
  assign ex_gnt = rst && sel_ex;

  // The grant cycle already stalls (the access is pending); the completion
  // cycle releases the pipeline even if a fresh EX request is granted there.
  assign stall = rst && ((state_q == BUSY_EX) ||
                         (ex_req && !ex_gnt) ||
                         (ex_gnt && !ex_done_q));

  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign ex_done   = ex_done_q;
  assign ex_rdata  = ex_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // DUT A: MEM_LATENCY=1, STARVE_LIMIT=4
  logic        rst, if_req, if_gnt, if_valid, ex_req, ex_we, ex_gnt, ex_done, stall, mem_en, mem_we;
  logic [31:0] if_addr, if_rdata, ex_addr, ex_wdata, ex_rdata, mem_addr, mem_wdata, mem_rdata;
  // DUT B: MEM_LATENCY=3
  logic        b_rst, b_if_req, b_if_gnt, b_if_valid, b_ex_req, b_ex_we, b_ex_gnt, b_ex_done, b_stall, b_mem_en, b_mem_we;
  logic [31:0] b_if_addr, b_if_rdata, b_ex_addr, b_ex_wdata, b_ex_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_arbiter #(.XLEN(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_gnt(ex_gnt), .ex_done(ex_done), .ex_rdata(ex_rdata), .stall(stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.XLEN(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u_dut_b (
    .clk(clk), .rst(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_valid(b_if_valid), .if_rdata(b_if_rdata),
    .ex_req(b_ex_req), .ex_we(b_ex_we), .ex_addr(b_ex_addr), .ex_wdata(b_ex_wdata),
    .ex_gnt(b_ex_gnt), .ex_done(b_ex_done), .ex_rdata(b_ex_rdata), .stall(b_stall),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Memory A: one-cycle latency, stores update the array.
  logic [31:0] mem_a [logic [31:0]];

  function automatic logic [31:0] rd_a(input logic [31:0] a);
    if (mem_a.exists(a)) return mem_a[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  initial begin : mem_model_a
    logic        s_en, s_we;
    logic [31:0] s_addr, s_wd;
    mem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wd = mem_wdata;
      @(posedge clk);
      #1;
      if (s_en && s_we) mem_a[s_addr] = s_wd;
      mem_rdata = (s_en && !s_we) ? rd_a(s_addr) : 32'hBAD0_BAD0;
    end
  end

  // Memory B: three-cycle latency, read-only pattern.
  initial begin : mem_model_b
    logic        s_en;
    logic [31:0] s_addr;
    logic [31:0] pb [3];
    for (int i = 0; i < 3; i++) pb[i] = 32'hBAD0_BAD0;
    b_mem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      s_en = b_mem_en; s_addr = b_mem_addr;
      @(posedge clk);
      #1;
      pb[2] = pb[1];
      pb[1] = pb[0];
      pb[0] = s_en ? (s_addr ^ 32'hA5A5_0000) : 32'hBAD0_BAD0;
      b_mem_rdata = pb[2];
    end
  end

  // Scoreboard for DUT A: expected data and completion cycle per accepted request.
  typedef struct {
    logic [31:0] dat;
    int          cyc;
  } exp_t;
  exp_t        if_q[$];
  exp_t        ex_q[$];
  logic [31:0] last_ld = 32'h0;

  task automatic push_if(input logic [31:0] a);
    exp_t e;
    e.dat = rd_a(a);
    e.cyc = cyc + 3;
    if_q.push_back(e);
  endtask

  task automatic push_ex(input logic we, input logic [31:0] a);
    exp_t e;
    if (!we) last_ld = rd_a(a);
    e.dat = last_ld;
    e.cyc = cyc + 3;
    ex_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor_a
    exp_t e;
    if (if_valid) begin
      if (if_q.size() == 0) begin
        chk("if_valid_spurious", 32'(if_valid), 32'd0);
      end else begin
        e = if_q.pop_front();
        chk("if_rdata", if_rdata, e.dat);
        chk("if_valid_cycle", cyc, e.cyc);
      end
    end
    if (ex_done) begin
      if (ex_q.size() == 0) begin
        chk("ex_done_spurious", 32'(ex_done), 32'd0);
      end else begin
        e = ex_q.pop_front();
        chk("ex_rdata", ex_rdata, e.dat);
        chk("ex_done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time 100000 exceeded, expected completion earlier");
    $fatal(1);
  end

  int          exp_g [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  logic [31:0] b2b_addr [3] = '{32'h0, 32'h4, 32'h8};

  initial begin
    int k, j, nv, g, vc;
    int vcyc [3];

    rst = 1'b0; if_req = 1'b1; if_addr = 32'h10; ex_req = 1'b1; ex_we = 1'b0; ex_addr = 32'h20; ex_wdata = 32'h0;
    b_rst = 1'b0; b_if_req = 1'b0; b_if_addr = 32'h0; b_ex_req = 1'b0; b_ex_we = 1'b0; b_ex_addr = 32'h0; b_ex_wdata = 32'h0;

    // Reset state, requests asserted but must not be granted.
    @(negedge clk);
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_ex_gnt", 32'(ex_gnt), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_ex_rdata", ex_rdata, 32'd0);
    nxt();
    if_req = 1'b0; ex_req = 1'b0;
    rst = 1'b1; b_rst = 1'b1;
    nxt(); nxt();

    // Single fetch.
    mem_a[32'h100] = 32'h0050_0093;
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    chk("t1_if_gnt", 32'(if_gnt), 32'd1);
    chk("t1_ex_gnt", 32'(ex_gnt), 32'd0);
    chk("t1_mem_en_c0", 32'(mem_en), 32'd0);
    push_if(32'h100);
    nxt(); if_req = 1'b0;
    @(negedge clk);
    chk("t1_mem_en_c1", 32'(mem_en), 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_we", 32'(mem_we), 32'd0);
    chk("t1_stall", 32'(stall), 32'd0);
    nxt();
    @(negedge clk);
    chk("t1_mem_en_c2", 32'(mem_en), 32'd0);
    nxt();
    @(negedge clk);
    chk("t1_if_valid_c3", 32'(if_valid), 32'd1);
    nxt();

    // Simultaneous IF and EX load: EX first, IF granted at ex_done.
    mem_a[32'h2000] = 32'h1234_5678;
    if_req = 1'b1; if_addr = 32'h104; ex_req = 1'b1; ex_we = 1'b0; ex_addr = 32'h2000;
    @(negedge clk);
    chk("t2_ex_gnt", 32'(ex_gnt), 32'd1);
    chk("t2_if_gnt_c0", 32'(if_gnt), 32'd0);
    chk("t2_stall_c0", 32'(stall), 32'd1);
    push_ex(1'b0, 32'h2000);
    nxt(); ex_req = 1'b0;
    @(negedge clk);
    chk("t2_stall_c1", 32'(stall), 32'd1);
    chk("t2_if_gnt_c1", 32'(if_gnt), 32'd0);
    chk("t2_mem_addr", mem_addr, 32'h2000);
    nxt();
    @(negedge clk);
    chk("t2_stall_c2", 32'(stall), 32'd1);
    chk("t2_if_gnt_c2", 32'(if_gnt), 32'd0);
    nxt();
    @(negedge clk);
    chk("t2_stall_c3", 32'(stall), 32'd0);
    chk("t2_ex_done_c3", 32'(ex_done), 32'd1);
    chk("t2_if_gnt_c3", 32'(if_gnt), 32'd1);
    push_if(32'h104);
    nxt(); if_req = 1'b0;
    nxt(); nxt(); nxt();

    // Store.
    ex_req = 1'b1; ex_we = 1'b1; ex_addr = 32'h40; ex_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t3_ex_gnt", 32'(ex_gnt), 32'd1);
    push_ex(1'b1, 32'h40);
    nxt(); ex_req = 1'b0; ex_we = 1'b0;
    @(negedge clk);
    chk("t3_mem_en", 32'(mem_en), 32'd1);
    chk("t3_mem_we", 32'(mem_we), 32'd1);
    chk("t3_mem_addr", mem_addr, 32'h40);
    chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t3_stall", 32'(stall), 32'd1);
    nxt(); nxt();
    @(negedge clk);
    chk("t3_ex_done", 32'(ex_done), 32'd1);
    chk("t3_ex_rdata_kept", ex_rdata, 32'h1234_5678);
    nxt();

    // Starvation bound with both requests held.
    if_req = 1'b1; if_addr = 32'h200; ex_req = 1'b1; ex_we = 1'b0; ex_addr = 32'h80;
    k = 0;
    for (int i = 0; i < 40 && k < 10; i++) begin
      @(negedge clk);
      if (ex_gnt || if_gnt) begin
        chk($sformatf("t4_grant%0d_is_ex", k), 32'(ex_gnt), 32'(exp_g[k]));
        chk($sformatf("t4_grant%0d_onehot", k), 32'(ex_gnt & if_gnt), 32'd0);
        if (ex_gnt) push_ex(1'b0, 32'h80);
        else        push_if(32'h200);
        k++;
      end
      nxt();
    end
    chk("t4_grant_count", k, 10);
    if_req = 1'b0; ex_req = 1'b0;
    nxt(); nxt(); nxt();

    // Back-to-back fetches.
    j = 0; nv = 0;
    if_req = 1'b1; if_addr = b2b_addr[0];
    for (int i = 0; i < 30 && nv < 3; i++) begin
      @(negedge clk);
      if (if_gnt && j < 3) begin
        push_if(if_addr);
        j++;
      end
      if (if_valid) begin
        vcyc[nv] = cyc;
        nv++;
      end
      nxt();
      if (j >= 3) if_req = 1'b0;
      else        if_addr = b2b_addr[j];
    end
    chk("t5_valid_count", nv, 3);
    chk("t5_spacing_01", vcyc[1] - vcyc[0], 3);
    chk("t5_spacing_12", vcyc[2] - vcyc[1], 3);

    // DUT B: reset in the second BUSY_EX cycle.
    b_ex_req = 1'b1; b_ex_addr = 32'h500;
    @(negedge clk);
    chk("t6_ex_gnt", 32'(b_ex_gnt), 32'd1);
    nxt(); b_ex_req = 1'b0;
    @(negedge clk);
    chk("t6_mem_en", 32'(b_mem_en), 32'd1);
    chk("t6_stall_busy", 32'(b_stall), 32'd1);
    nxt();
    b_rst = 1'b0; b_ex_req = 1'b1;
    @(negedge clk);
    chk("t6_rst_ex_gnt", 32'(b_ex_gnt), 32'd0);
    chk("t6_rst_if_gnt", 32'(b_if_gnt), 32'd0);
    chk("t6_rst_stall", 32'(b_stall), 32'd0);
    chk("t6_rst_mem_en", 32'(b_mem_en), 32'd0);
    chk("t6_rst_mem_we", 32'(b_mem_we), 32'd0);
    chk("t6_rst_mem_addr", b_mem_addr, 32'd0);
    chk("t6_rst_mem_wdata", b_mem_wdata, 32'd0);
    chk("t6_rst_ex_done", 32'(b_ex_done), 32'd0);
    chk("t6_rst_if_valid", 32'(b_if_valid), 32'd0);
    chk("t6_rst_ex_rdata", b_ex_rdata, 32'd0);
    chk("t6_rst_if_rdata", b_if_rdata, 32'd0);
    nxt();
    b_rst = 1'b1; b_ex_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("t6_no_done_%0d", i), 32'(b_ex_done), 32'd0);
      chk($sformatf("t6_rdata_zero_%0d", i), b_ex_rdata, 32'd0);
      chk($sformatf("t6_idle_mem_en_%0d", i), 32'(b_mem_en), 32'd0);
      nxt();
    end
    b_if_req = 1'b1; b_if_addr = 32'h300;
    @(negedge clk);
    chk("t6_if_gnt", 32'(b_if_gnt), 32'd1);
    g = cyc;
    vc = -1;
    nxt(); b_if_req = 1'b0;
    for (int i = 0; i < 12 && vc < 0; i++) begin
      @(negedge clk);
      if (b_if_valid) begin
        vc = cyc;
        chk("t6_if_rdata", b_if_rdata, 32'hA5A5_0300);
      end
      nxt();
    end
    chk("t6_if_latency", vc - g, 5);

    nxt(); nxt();
    chk("sb_if_left", if_q.size(), 0);
    chk("sb_ex_left", ex_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
